nzcv_flag_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle 64-bit zero detector. Generates N and Z from an ALU result, and captures C and V from the adder.
- Supports 64-bit and 32-bit operand modes.
- Holds the architectural NZCV register and updates it only for flag-setting ops.
- Sits between the EX-stage ALU and the branch/condition unit. Provides stall and flush hooks for the pipeline controller.

---
 rtl/nzcv_flag_pipe.sv | 106 ++++++++++
 tb/tb_nzcv_flag_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nzcv_flag_pipe.sv
// Two-stage NZCV flag pipeline: stage 1 folds the ALU result into group ORs, stage 2 retires Z/N/C/V.
// Optional FLAG_BYPASS_EN adds flags_next, the value flags_q will take at the coming edge.
module nzcv_flag_pipe #(
  parameter int WIDTH  = 64,
  parameter int NARROW = 32,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_set_flags,
  input  logic             in_wide,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       flags_q,
  output logic             flags_pending,
  output logic             upd_valid,
  output logic             zero_out,
  output logic             zero_valid
`ifdef FLAG_BYPASS_EN
  ,
  output logic [3:0]       flags_next
`endif
);

  localparam int NUM_GROUPS    = WIDTH / GROUP;
  localparam int NARROW_GROUPS = NARROW / GROUP;

  logic [NUM_GROUPS-1:0] grp_d;
  logic                  n_d;

  logic [NUM_GROUPS-1:0] s1_grp;
  logic                  s1_n;
  logic                  s1_c;
  logic                  s1_v;
  logic                  s1_set;
  logic                  s1_valid;

  logic                  z;
  logic                  retire;

  // Narrow mode masks every group that lies above the low NARROW bits.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    grp_d = '0;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      grp_d[i] = (|in_result[i*GROUP +: GROUP]) & (in_wide | (i < NARROW_GROUPS));
    end
  end

  assign n_d = in_wide ? in_result[WIDTH-1] : in_result[NARROW-1];

  // Stage 1: flush beats stall; a stalled stage keeps its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
      s1_valid <= 1'b0;
      s1_set   <= 1'b0;
      s1_grp   <= '0;
      s1_n     <= 1'b0;
      s1_c     <= 1'b0;
      s1_v     <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_set   <= in_valid & in_set_flags;
      s1_grp   <= grp_d;
      s1_n     <= n_d;
      s1_c     <= in_carry;
      s1_v     <= in_overflow;
    end
  end

  assign z             = ~|s1_grp;
  assign retire        = s1_valid & ~stall & ~flush;
  assign flags_pending = s1_valid & s1_set;

  // Stage 2: retire into the architectural register; flags are never rolled back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q    <= 4'b0000;
      upd_valid  <= 1'b0;
      zero_out   <= 1'b0;
      zero_valid <= 1'b0;
    end else if (retire) begin
      zero_out   <= z;
      zero_valid <= 1'b1;
      upd_valid  <= s1_set;
      if (s1_set) begin
        flags_q <= {s1_n, z, s1_c, s1_v};
      end
    end else begin
      zero_valid <= 1'b0;
      upd_valid  <= 1'b0;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign flags_next = (retire & s1_set) ? {s1_n, z, s1_c, s1_v} : flags_q;
`endif

endmodule

// File: tb/tb_nzcv_flag_pipe.sv
// Self-checking bench for nzcv_flag_pipe: directed scenarios plus randomized traffic
// against a reference model that works on whole result values rather than group ORs.
module tb_nzcv_flag_pipe;

  localparam int WIDTH  = 64;
  localparam int NARROW = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_set_flags;
  logic             in_wide;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_overflow;
  logic             stall;
  logic             flush;
  logic [3:0]       flags_q;
  logic             flags_pending;
  logic             upd_valid;
  logic             zero_out;
  logic             zero_valid;
`ifdef FLAG_BYPASS_EN
  logic [3:0]       flags_next;
`endif

  int checks = 0;
  int errors = 0;

  nzcv_flag_pipe #(.WIDTH(WIDTH), .NARROW(NARROW), .GROUP(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_set_flags (in_set_flags),
    .in_wide      (in_wide),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .stall        (stall),
    .flush        (flush),
    .flags_q      (flags_q),
    .flags_pending(flags_pending),
    .upd_valid    (upd_valid),
    .zero_out     (zero_out),
    .zero_valid   (zero_valid)
`ifdef FLAG_BYPASS_EN
    ,
    .flags_next   (flags_next)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the op in flight is kept as its raw inputs.
  logic             m_valid, m_set, m_wide, m_c, m_v;
  logic [WIDTH-1:0] m_result;
  logic [3:0]       m_flags;
  logic             m_upd, m_zero, m_zv;

  function automatic logic [3:0] op_flags(input logic wide, input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    logic n, zz;
    if (wide) begin
      zz = (r == '0);
      n  = r[WIDTH-1];
    end else begin
      zz = (r[NARROW-1:0] == '0);
      n  = r[NARROW-1];
    end
    return {n, zz, c, v};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_set = 0; m_wide = 0; m_c = 0; m_v = 0; m_result = '0;
    m_flags = 4'b0000; m_upd = 0; m_zero = 0; m_zv = 0;
  endtask

  task automatic model_edge();
    logic [3:0] f;
    if (m_valid && !stall && !flush) begin
      f      = op_flags(m_wide, m_result, m_c, m_v);
      m_zero = f[2];
      m_zv   = 1;
      m_upd  = m_set;
      if (m_set) m_flags = f;
    end else begin
      m_zv  = 0;
      m_upd = 0;
    end
    if (flush) begin
      m_valid = 0;
    end else if (!stall) begin
      m_valid  = in_valid;
      m_set    = in_valid & in_set_flags;
      m_wide   = in_wide;
      m_result = in_result;
      m_c      = in_carry;
      m_v      = in_overflow;
    end
  endtask

  // Apply inputs at the falling edge, advance one rising edge, return at the next falling edge.
  task automatic drive_cycle(input logic v, input logic s, input logic w, input logic [WIDTH-1:0] r,
                             input logic c, input logic o, input logic st, input logic fl);
    in_valid = v; in_set_flags = s; in_wide = w; in_result = r;
    in_carry = c; in_overflow = o; stall = st; flush = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    drive_cycle(0, 0, 1, '0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 0;
    in_valid = 1; in_set_flags = 1; in_wide = 1; in_result = '0;
    in_carry = 1; in_overflow = 1; stall = 0; flush = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1;
    in_valid = 0; in_set_flags = 0;
    checks++;
    if (flags_q !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags_q); end
    checks++;
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", upd_valid); end
    checks++;
    if (zero_valid !== 1'b0) begin errors++; $display("FAIL reset_zv got %b want 0", zero_valid); end
    checks++;
    if (flags_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", flags_pending); end
    checks++;
    if (zero_out !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero_out); end
  endtask

  task automatic test_wide_zero();
    drive_cycle(1, 1, 1, '0, 1, 0, 0, 0);
    checks++;
    if (flags_pending !== 1'b1 || upd_valid !== 1'b0) begin
      errors++; $display("FAIL wz_stage1 pending=%b upd=%b want 1 0", flags_pending, upd_valid);
    end
    idle();
    checks++;
    if (flags_q !== 4'b0110 || upd_valid !== 1'b1) begin
      errors++; $display("FAIL wz_retire flags=%b upd=%b want 0110 1", flags_q, upd_valid);
    end
    checks++;
    if (zero_out !== 1'b1 || zero_valid !== 1'b1 || flags_pending !== 1'b0) begin
      errors++; $display("FAIL wz_zero zero=%b zv=%b pend=%b want 1 1 0", zero_out, zero_valid, flags_pending);
    end
    idle();
    checks++;
    if (upd_valid !== 1'b0 || zero_valid !== 1'b0 || flags_q !== 4'b0110) begin
      errors++; $display("FAIL wz_pulse upd=%b zv=%b flags=%b want 0 0 0110", upd_valid, zero_valid, flags_q);
    end
  endtask

  task automatic test_narrow_mask();
    drive_cycle(1, 1, 0, 64'hFFFF_FFFF_0000_0000, 0, 0, 0, 0);
    idle();
    checks++;
    if (flags_q !== 4'b0100) begin errors++; $display("FAIL narrow flags=%b want 0100", flags_q); end
    drive_cycle(1, 1, 1, 64'hFFFF_FFFF_0000_0000, 0, 0, 0, 0);
    idle();
    checks++;
    if (flags_q !== 4'b1000) begin errors++; $display("FAIL wide_same flags=%b want 1000", flags_q); end
    drive_cycle(1, 1, 0, 64'h0000_0000_8000_0000, 1, 1, 0, 0);
    idle();
    checks++;
    if (flags_q !== 4'b1011) begin errors++; $display("FAIL narrow_n flags=%b want 1011", flags_q); end
    drive_cycle(1, 1, 1, 64'hFFFF_FFFF_0000_0000, 0, 0, 0, 0);
    idle();
  endtask

  task automatic test_no_set();
    drive_cycle(1, 0, 1, '0, 1, 1, 0, 0);
    idle();
    checks++;
    if (zero_out !== 1'b1 || zero_valid !== 1'b1) begin
      errors++; $display("FAIL noset_zero zero=%b zv=%b want 1 1", zero_out, zero_valid);
    end
    checks++;
    if (flags_q !== 4'b1000 || upd_valid !== 1'b0) begin
      errors++; $display("FAIL noset_flags flags=%b upd=%b want 1000 0", flags_q, upd_valid);
    end
  endtask

  task automatic test_stall();
    drive_cycle(1, 1, 1, 64'd5, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 1, 1, '0, 1, 0, 1, 0);
      checks++;
      if (flags_pending !== 1'b1 || upd_valid !== 1'b0 || zero_valid !== 1'b0 || flags_q !== 4'b1000) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d pend=%b upd=%b zv=%b flags=%b want 1 0 0 1000",
                 i, flags_pending, upd_valid, zero_valid, flags_q);
      end
    end
    idle();
    checks++;
    if (flags_q !== 4'b0001 || upd_valid !== 1'b1 || flags_pending !== 1'b0) begin
      errors++; $display("FAIL stall_release flags=%b upd=%b pend=%b want 0001 1 0", flags_q, upd_valid, flags_pending);
    end
  endtask

  task automatic test_flush();
    drive_cycle(1, 1, 1, '0, 1, 0, 0, 0);
    drive_cycle(1, 1, 1, '0, 1, 1, 0, 1);
    checks++;
    if (upd_valid !== 1'b0 || flags_pending !== 1'b0 || zero_valid !== 1'b0 || flags_q !== 4'b0001) begin
      errors++; $display("FAIL flush_kill upd=%b pend=%b zv=%b flags=%b want 0 0 0 0001",
                         upd_valid, flags_pending, zero_valid, flags_q);
    end
    idle();
    checks++;
    if (upd_valid !== 1'b0 || flags_q !== 4'b0001) begin
      errors++; $display("FAIL flush_input upd=%b flags=%b want 0 0001", upd_valid, flags_q);
    end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1, 1, 1, 64'd5, 0, 0, 0, 0);
    drive_cycle(1, 1, 1, '0, 0, 0, 0, 0);
    checks++;
    if (flags_q !== 4'b0000 || upd_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first flags=%b upd=%b want 0000 1", flags_q, upd_valid);
    end
    idle();
    checks++;
    if (flags_q !== 4'b0100 || upd_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second flags=%b upd=%b want 0100 1", flags_q, upd_valid);
    end
    idle();
    checks++;
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end upd=%b want 0", upd_valid); end
  endtask

  task automatic test_mid_reset();
    drive_cycle(1, 1, 1, 64'h8000_0000_0000_0001, 1, 1, 0, 0);
    reset_n = 0;
    #1;
    model_reset();
    checks++;
    if (flags_q !== 4'b0000 || flags_pending !== 1'b0 || upd_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_async flags=%b pend=%b upd=%b want 0000 0 0", flags_q, flags_pending, upd_valid);
    end
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if (upd_valid !== 1'b0 || zero_valid !== 1'b0 || flags_q !== 4'b0000) begin
        errors++; $display("FAIL midrst_after cyc=%0d upd=%b zv=%b flags=%b want 0 0 0000",
                           i, upd_valid, zero_valid, flags_q);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] r;
    logic             st, fl;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = {32'($urandom), 32'h0};
        2:       r = {32'h0, 32'($urandom)};
        default: r = {32'($urandom), 32'($urandom)};
      endcase
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 3) != 0); in_set_flags = 1'($urandom); in_wide = 1'($urandom);
      in_result = r; in_carry = 1'($urandom); in_overflow = 1'($urandom); stall = st; flush = fl;
`ifdef FLAG_BYPASS_EN
      #1;
      checks++;
      if (flags_next !== ((m_valid && m_set && !st && !fl) ? op_flags(m_wide, m_result, m_c, m_v) : m_flags)) begin
        errors++; $display("FAIL rand_bypass cyc=%0d got %b", i, flags_next);
      end
`endif
      @(posedge clk);
      model_edge();
      @(negedge clk);
      checks++;
      if (flags_q !== m_flags || upd_valid !== m_upd || zero_valid !== m_zv ||
          (m_zv && zero_out !== m_zero) || flags_pending !== (m_valid & m_set)) begin
        errors++;
        $display("FAIL rand cyc=%0d flags=%b/%b upd=%b/%b zv=%b/%b zero=%b/%b pend=%b/%b (got/want)",
                 i, flags_q, m_flags, upd_valid, m_upd, zero_valid, m_zv, zero_out, m_zero,
                 flags_pending, m_valid & m_set);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wide_zero();
    test_narrow_mask();
    test_no_set();
    test_stall();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
